rectangle128_key_ctrl: RTL and testbench
========================================

RECTANGLE128_KEY_CTRL -- requirements
Module: rectangle128_key_ctrl

Interface
REQ-001 SHALL use a single clock, Clk; reset is synchronous and active-high.
REQ-002 Clk  in  1  clock; all state is updated on the rising edge.
REQ-003 Rst  in  1  synchronous active-high reset.
REQ-004 key_valid  in  1  new 128-bit master key offered.
REQ-005 key_ready  out  1  controller can accept a key.
REQ-006 key0, key1  in  64 each  master key halves; sampled on the handshake.
REQ-007 gen_key0, gen_key1  out  64 each  registered copy of the accepted key, driven to the subkey generator.
REQ-008 gen_clear  out  1  active-high reset to the subkey generator (inverted externally to its RstN).
REQ-009 gen_en  out  1  Enable to the subkey generator.
REQ-010 gen_we  in  1  generator write strobe.
REQ-011 gen_waddr  in  5  generator write address.
REQ-012 gen_keyin  in  64  generator round key.
REQ-013 rk_req  in  1  round-key read request from the cipher core.
REQ-014 rk_idx  in  5  requested round index.
REQ-015 rk_ack  out  1  read response valid; asserted for 1 cycle.
REQ-016 rk_data  out  64  round key.
REQ-017 rk_err  out  1  index out of range; qualified by rk_ack.
REQ-018 keys_valid  out  1  all 26 round keys for the current key are stored.
REQ-019 busy  out  1  expansion in progress.

Function
REQ-020 SHALL contain a 26x64 round-key store; contents are not reset.
REQ-021 SHALL implement FSM states IDLE, CLEAR, EXPAND and READY.
REQ-022 key_ready SHALL be 1 in IDLE and READY, and 0 in CLEAR and EXPAND.
REQ-023 On key_valid&&key_ready: capture key0/key1 into gen_key0/gen_key1, deassert keys_valid at the same edge, next state CLEAR.
REQ-024 CLEAR: 1 cycle; gen_clear=1, gen_en=0; next state EXPAND.
REQ-025 EXPAND: gen_en=1, gen_clear=0, busy=1.
  - When gen_we=1 and gen_waddr<=25, write gen_keyin into store[gen_waddr].
  - gen_we=1 with gen_waddr>25 is ignored.
REQ-026 EXPAND exits to READY on the edge that writes gen_waddr==25; keys_valid=1 from that edge.
REQ-027 With a conforming generator, keys_valid SHALL rise exactly 28 rising edges after the accept edge. The accept edge is counted as edge 0.
REQ-028 gen_clear SHALL equal Rst OR (state==CLEAR); gen_en SHALL be 1 only in EXPAND.
REQ-029 Reads are served only in READY.
  - rk_req=1 in READY: the next cycle has rk_ack=1 and rk_data=store[rk_idx] sampled at the request edge.
  - If rk_idx>25: rk_err=1 and rk_data=0 instead.
REQ-030 rk_req outside READY SHALL get no ack; the requester holds rk_req until acked.
REQ-031 A request held continuously in READY is acked every cycle (1 read per cycle).
REQ-032 rk_req and a key accept in the same READY cycle: the read is served with pre-change data, then the FSM moves to CLEAR.
REQ-033 key_valid during CLEAR/EXPAND SHALL be ignored (key_ready=0); the in-flight expansion completes undisturbed.
REQ-034 rk_data and rk_err SHALL be 0 whenever rk_ack=0.

Reset
REQ-035 Rst=1 at any edge, including mid-EXPAND, SHALL give: state IDLE, key_ready=1, keys_valid=0, busy=0, gen_en=0, rk_ack=0, rk_data=0, rk_err=0, gen_key0=gen_key1=0.
REQ-036 While Rst=1, gen_clear=1.
REQ-037 After reset, stale store contents are unreadable until a new expansion completes.

Verification
REQ-038 Reset, then accept key0=key1=0 with a generator model attached -> keys_valid=1 exactly 28 edges later; busy=1 for 27 cycles; gen_clear pulses 1 cycle.
REQ-039 READY, rk_req with rk_idx=0..25 back-to-back -> 26 consecutive acks with data matching the golden RECTANGLE128 schedule; rk_idx=26 and 31 -> rk_err=1, rk_data=0.
REQ-040 rk_req held during EXPAND -> no ack until the READY edge, then ack on the next cycle with the new key's data.
REQ-041 In READY, accept key0=64'hFFFF_FFFF_FFFF_FFFF while rk_req=1, rk_idx=3 -> ack carries the old key's round 3; keys_valid drops at the same edge.
REQ-042 Rst at EXPAND write 10 -> IDLE next cycle with all outputs at reset values; re-accept completes in 28 edges.
REQ-043 key_valid pulsed during EXPAND -> ignored; gen_key0/gen_key1 unchanged; resulting round keys match the first key.

Source files
------------

// File: rtl/rectangle128_key_ctrl.sv
// RECTANGLE-128 round-key controller: accepts a master key, drives an external
// subkey generator, stores its 26 round keys and serves single-cycle reads.
module rectangle128_key_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key0,
    input  logic [63:0] key1,
    output logic [63:0] gen_key0,
    output logic [63:0] gen_key1,
    output logic        gen_clear,
    output logic        gen_en,
    input  logic        gen_we,
    input  logic [4:0]  gen_waddr,
    input  logic [63:0] gen_keyin,
    input  logic        rk_req,
    input  logic [4:0]  rk_idx,
    output logic        rk_ack,
    output logic [63:0] rk_data,
    output logic        rk_err,
    output logic        keys_valid,
    output logic        busy
);

    localparam int          NUM_RK  = 26;
    localparam logic [4:0]  LAST_RK = 5'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        EXPAND = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_key_ready;
    logic        r_gen_en;
    logic        r_busy;
    logic        r_keys_valid;
    logic [63:0] r_gen_key0;
    logic [63:0] r_gen_key1;
    logic        r_rk_ack;
    logic        r_rk_err;
    logic [63:0] r_rk_data;

    // Round-key store; never reset, guarded by keys_valid/READY instead.
    logic [63:0] r_store [NUM_RK];

    logic w_accept;
    logic w_wr;
    logic w_wr_last;
    logic w_rd;
    logic w_idx_bad;

    assign w_accept  = key_valid && r_key_ready;
    assign w_wr      = (r_state == EXPAND) && gen_we && (gen_waddr <= LAST_RK);
    assign w_wr_last = w_wr && (gen_waddr == LAST_RK);
    assign w_rd      = (r_state == READY) && rk_req;
    assign w_idx_bad = rk_idx > LAST_RK;

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_store[gen_waddr] <= gen_keyin;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_key_ready  <= 1'b1;
            r_gen_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_gen_key0   <= '0;
            r_gen_key1   <= '0;
            r_rk_ack     <= 1'b0;
            r_rk_err     <= 1'b0;
            r_rk_data    <= '0;
        end else begin
            // Read response: a read and a key accept in the same READY cycle
            // still see the old store, since the store only changes in EXPAND.
            r_rk_ack  <= w_rd;
            r_rk_err  <= w_rd && w_idx_bad;
            r_rk_data <= (w_rd && !w_idx_bad) ? r_store[rk_idx] : '0;

            case (r_state)
                IDLE, READY: begin
                    if (w_accept) begin
                        r_gen_key0   <= key0;
                        r_gen_key1   <= key1;
                        r_keys_valid <= 1'b0;
                        r_key_ready  <= 1'b0;
                        r_state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_gen_en <= 1'b1;
                    r_busy   <= 1'b1;
                    r_state  <= EXPAND;
                end
                EXPAND: begin
                    if (w_wr_last) begin
                        r_gen_en     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_keys_valid <= 1'b1;
                        r_key_ready  <= 1'b1;
                        r_state      <= READY;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The generator is held cleared for the whole reset, not only in CLEAR.
    assign gen_clear  = Rst || (r_state == CLEAR);
    assign gen_en     = r_gen_en;
    assign key_ready  = r_key_ready;
    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;
    assign gen_key0   = r_gen_key0;
    assign gen_key1   = r_gen_key1;
    assign rk_ack     = r_rk_ack;
    assign rk_err     = r_rk_err;
    assign rk_data    = r_rk_data;

endmodule

// File: tb/tb_rectangle128_key_ctrl.sv
// Bench for rectangle128_key_ctrl: behavioural RECTANGLE-128 subkey generator
// attached to the controller, round-key reads checked through a scoreboard.
module tb_rectangle128_key_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key0 = '0;
    logic [63:0] key1 = '0;
    logic [63:0] gen_key0;
    logic [63:0] gen_key1;
    logic        gen_clear;
    logic        gen_en;
    logic        gen_we;
    logic [4:0]  gen_waddr;
    logic [63:0] gen_keyin;
    logic        rk_req = 1'b0;
    logic [4:0]  rk_idx = '0;
    logic        rk_ack;
    logic [63:0] rk_data;
    logic        rk_err;
    logic        keys_valid;
    logic        busy;

    rectangle128_key_ctrl dut (
        .Clk(Clk), .Rst(Rst), .key_valid(key_valid), .key_ready(key_ready),
        .key0(key0), .key1(key1), .gen_key0(gen_key0), .gen_key1(gen_key1),
        .gen_clear(gen_clear), .gen_en(gen_en), .gen_we(gen_we),
        .gen_waddr(gen_waddr), .gen_keyin(gen_keyin), .rk_req(rk_req),
        .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_data(rk_data), .rk_err(rk_err),
        .keys_valid(keys_valid), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- RECTANGLE-128 key schedule model ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h6; 4'h1: return 4'h5; 4'h2: return 4'hC; 4'h3: return 4'hA;
            4'h4: return 4'h1; 4'h5: return 4'hE; 4'h6: return 4'h7; 4'h7: return 4'h9;
            4'h8: return 4'hB; 4'h9: return 4'h0; 4'hA: return 4'h3; 4'hB: return 4'hD;
            4'hC: return 4'h8; 4'hD: return 4'hF; 4'hE: return 4'h4; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] rk_of(input logic [127:0] k);
        return {k[111:96], k[79:64], k[47:32], k[15:0]};
    endfunction

    function automatic logic [4:0] rc_next(input logic [4:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

    function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [4:0] rc);
        logic [31:0] r0, r1, r2, r3, n0;
        logic [3:0]  s;
        r0 = k[31:0]; r1 = k[63:32]; r2 = k[95:64]; r3 = k[127:96];
        for (int j = 0; j < 8; j++) begin
            s = sbox({r3[j], r2[j], r1[j], r0[j]});
            r0[j] = s[0]; r1[j] = s[1]; r2[j] = s[2]; r3[j] = s[3];
        end
        n0 = {r0[23:0], r0[31:24]} ^ r1;
        n0[4:0] = n0[4:0] ^ rc;
        return {r0, {r2[15:0], r2[31:16]} ^ r3, r2, n0};
    endfunction

    function automatic logic [63:0] golden(input logic [127:0] k, input int r);
        logic [127:0] kk;
        logic [4:0]   rc;
        kk = k; rc = 5'd1;
        for (int i = 0; i < r; i++) begin
            kk = ks_step(kk, rc);
            rc = rc_next(rc);
        end
        return rk_of(kk);
    endfunction

    // ---------------- Generator model (registered write port) ----------------
    logic [127:0] g_key = '0;
    logic [4:0]   g_rc = 5'd1;
    int           g_cnt = 0;
    logic         g_we = 1'b0;
    logic [4:0]   g_waddr = '0;
    logic [63:0]  g_keyin = '0;

    always @(posedge Clk) begin
        if (gen_clear) begin
            g_key <= {gen_key1, gen_key0};
            g_rc  <= 5'd1;
            g_cnt <= 0;
            g_we  <= 1'b0;
        end else if (gen_en && g_cnt <= 25) begin
            g_we    <= 1'b1;
            g_waddr <= 5'(g_cnt);
            g_keyin <= rk_of(g_key);
            g_key   <= ks_step(g_key, g_rc);
            g_rc    <= rc_next(g_rc);
            g_cnt   <= g_cnt + 1;
        end else begin
            g_we <= 1'b0;
        end
    end

    assign gen_we    = g_we;
    assign gen_waddr = g_waddr;
    assign gen_keyin = g_keyin;

    // ---------------- Scoreboard monitor ----------------
    logic [64:0]  sb[$];
    logic [64:0]  sb_exp;
    logic         mon_en = 1'b0;
    logic [127:0] cur_key = '0;

    always @(posedge Clk) begin
        #1;
        if (mon_en) begin
            if (rk_ack === 1'b1) begin
                if (sb.size() == 0) begin
                    check("rk_ack_unexpected", 1, 0);
                end else begin
                    sb_exp = sb.pop_front();
                    check("rk_read", {rk_err, rk_data}, sb_exp);
                end
            end else begin
                check("rk_idle_zero", {rk_err, rk_data}, 0);
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push_read(input logic [127:0] k, input int idx);
        if (idx > 25) sb.push_back({1'b1, 64'h0});
        else          sb.push_back({1'b0, golden(k, idx)});
    endtask

    // Accept a key and run the expansion; optional read on the accept edge,
    // request held through EXPAND, and a key_valid pulse inside EXPAND.
    task automatic run_expand(input logic [63:0] k0, input logic [63:0] k1,
                              input int acc_idx, input int hold_idx, input int pulse_edge);
        int edges, nbusy, nclr;
        key0 = k0; key1 = k1; key_valid = 1'b1;
        if (acc_idx >= 0) begin
            rk_req = 1'b1; rk_idx = 5'(acc_idx);
            push_read(cur_key, acc_idx);
        end
        tick;
        key_valid = 1'b0; rk_req = 1'b0;
        key0 = ~k0; key1 = ~k1;
        check("accept_keys_valid", keys_valid, 0);
        check("accept_key_ready", key_ready, 0);
        check("accept_gen_key0", gen_key0, k0);
        check("accept_gen_key1", gen_key1, k1);
        if (hold_idx >= 0) begin
            rk_req = 1'b1; rk_idx = 5'(hold_idx);
        end
        edges = 0; nbusy = 0; nclr = int'(gen_clear);
        while (keys_valid !== 1'b1 && edges < 60) begin
            tick;
            edges++;
            key_valid = (edges == pulse_edge);
            nbusy += int'(busy);
            nclr  += int'(gen_clear);
        end
        key_valid = 1'b0;
        check("kv_edges", edges, 28);
        check("busy_cycles", nbusy, 27);
        check("clear_pulses", nclr, 1);
        check("ready_after", key_ready, 1);
        check("hold_gen_key0", gen_key0, k0);
        check("hold_gen_key1", gen_key1, k1);
        cur_key = {k1, k0};
        if (hold_idx >= 0) begin
            push_read(cur_key, hold_idx);
            tick;
            rk_req = 1'b0;
        end
    endtask

    task automatic read_all;
        int idx;
        for (int i = 0; i < 28; i++) begin
            idx = (i < 26) ? i : ((i == 26) ? 26 : 31);
            rk_req = 1'b1; rk_idx = 5'(idx);
            push_read(cur_key, idx);
            tick;
        end
        rk_req = 1'b0;
        tick;
        tick;
        check("read_drain", sb.size(), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_keys_valid"}, keys_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_gen_en"}, gen_en, 0);
        check({tag, "_rk"}, {rk_ack, rk_err, rk_data}, 0);
        check({tag, "_gen_key"}, {gen_key1, gen_key0}, 0);
        check({tag, "_gen_clear"}, gen_clear, 1);
    endtask

    initial begin
        int n;
        Rst = 1'b1;
        tick;
        tick;
        check_reset_outs("rst0");
        Rst = 1'b0;
        #1;
        check("rst0_release_clear", gen_clear, 0);
        mon_en = 1'b1;

        // Zero key, full read-out including out-of-range indices.
        run_expand(64'h0, 64'h0, -1, -1, -1);
        read_all;

        // Request held across EXPAND.
        run_expand(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, -1, 5, -1);
        read_all;

        // Read served with old data on the accept edge.
        run_expand(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, -1, -1);
        read_all;

        // key_valid pulse inside EXPAND must be ignored.
        run_expand(64'hA5A5_0F0F_3C3C_9696, 64'h1357_9BDF_2468_ACE0, -1, -1, 10);
        read_all;

        // Reset during EXPAND at the write of round key 10.
        key0 = 64'hDEAD_BEEF_0000_1111; key1 = 64'h2222_3333_CAFE_F00D; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        n = 0;
        while (!(gen_we === 1'b1 && gen_waddr == 5'd10) && n < 60) begin
            tick;
            n++;
        end
        check("mid_rst_reached", n < 60, 1);
        Rst = 1'b1;
        #1;
        check("mid_rst_clear_comb", gen_clear, 1);
        tick;
        check_reset_outs("mid_rst");
        Rst = 1'b0;
        #1;
        check("mid_rst_release_clear", gen_clear, 0);
        rk_req = 1'b1; rk_idx = 5'd0;
        tick;
        tick;
        tick;
        rk_req = 1'b0;
        check("stale_keys_valid", keys_valid, 0);
        tick;
        run_expand(64'hDEAD_BEEF_0000_1111, 64'h2222_3333_CAFE_F00D, -1, -1, -1);
        read_all;

        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
